// File: rtl/block_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache between the CPU datapath and a 32 x 512-bit block memory.
// Optional feature: define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module block_cache_ctrl #(
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [8:0]   cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [4:0]   mem_address,
  output logic [511:0] mem_data_out,
  input  logic [511:0] mem_data_in
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int unsigned NUM_LINES = 1 << IDX_W;
  localparam int unsigned TAG_W     = 5 - IDX_W;
  localparam int unsigned CNT_W     = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 req_we_q, req_we_d;
  logic [8:0]           req_addr_q, req_addr_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic [511:0]         data_q [NUM_LINES];
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 cpu_ready_q, cpu_ready_d;
  logic [31:0]          cpu_rdata_q, cpu_rdata_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [4:0]           mem_address_q, mem_address_d;
  logic [511:0]         mem_data_out_q, mem_data_out_d;
`ifdef CACHE_STATS_EN
  logic [15:0]          hit_cnt_q, hit_cnt_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
`endif

  logic [IDX_W-1:0]     req_idx_c;
  logic [TAG_W-1:0]     req_tag_c;
  logic [3:0]           req_off_c;
  logic                 hit_c;
  logic [511:0]         line_cur_c;
  logic [511:0]         line_mod_c;
  logic                 data_we_c;
  logic [511:0]         data_wval_c;

  assign req_idx_c  = req_addr_q[3+IDX_W:4];
  assign req_tag_c  = req_addr_q[8:4+IDX_W];
  assign req_off_c  = req_addr_q[3:0];
  assign line_cur_c = data_q[req_idx_c];
  assign hit_c      = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);

  // Current line with the requested word replaced by the write data.
  always_comb begin
    line_mod_c = line_cur_c;
    line_mod_c[{req_off_c, 5'd0} +: 32] = req_wdata_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    wait_cnt_d     = wait_cnt_q;
    cpu_ready_d    = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    data_we_c      = 1'b0;
    data_wval_c    = mem_data_in;
`ifdef CACHE_STATS_EN
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_req && !cpu_ready_q) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
`ifdef CACHE_STATS_EN
        if (hit_c) begin
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
`endif
        if (hit_c) begin
          state_d = S_RESP;
        end else if (valid_q[req_idx_c] && dirty_q[req_idx_c]) begin
          state_d        = S_WB;
          mem_write_d    = 1'b1;
          mem_address_d  = {tag_q[req_idx_c], req_idx_c};
          mem_data_out_d = line_cur_c;
        end else begin
          state_d       = S_FILL;
          mem_read_d    = 1'b1;
          mem_address_d = req_addr_q[8:4];
        end
      end
      S_WB: begin
        dirty_d[req_idx_c] = 1'b0;
        state_d            = S_FILL;
        mem_read_d         = 1'b1;
        mem_address_d      = req_addr_q[8:4];
      end
      S_FILL: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (wait_cnt_q == CNT_W'(MEM_RD_LAT - 1)) begin
          data_we_c          = 1'b1;
          data_wval_c        = mem_data_in;
          valid_d[req_idx_c] = 1'b1;
          dirty_d[req_idx_c] = 1'b0;
          tag_d[req_idx_c]   = req_tag_c;
          state_d            = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        cpu_ready_d = 1'b1;
        state_d     = S_IDLE;
        if (req_we_q) begin
          data_we_c          = 1'b1;
          data_wval_c        = line_mod_c;
          dirty_d[req_idx_c] = 1'b1;
        end else begin
          cpu_rdata_d = line_cur_c[{req_off_c, 5'd0} +: 32];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
      wait_cnt_q     <= '0;
      cpu_ready_q    <= 1'b0;
      cpu_rdata_q    <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      tag_q          <= tag_d;
      wait_cnt_q     <= wait_cnt_d;
      cpu_ready_q    <= cpu_ready_d;
      cpu_rdata_q    <= cpu_rdata_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
`endif
    end
  end

  // Line data is deliberately unreset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (data_we_c) data_q[req_idx_c] <= data_wval_c;
  end

  assign cpu_ready    = cpu_ready_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
`ifdef CACHE_STATS_EN
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;
`endif

endmodule
